// File: rtl/addsub_sequencer.sv
// addsub_sequencer
// ----------------
// Multi-cycle controller that time-shares one combinational WIDTH-bit adder
// and one bitwise inverter bank to perform ADD, SUB, NEG and PASS for the ALU.
// SUB takes two adder passes: first ~b+1 into a temp register, then a+temp.
// ADD, NEG and PASS finish in a single adder pass.
//
// Optional feature macro: ADDSUB_SEQ_FLAGS_EN
//   defined   : c_out and ovf are computed and registered on completion.
//   undefined : flag logic is removed and c_out/ovf are tied to 0; result,
//               timing and handshake are identical.
//
// Parameters
//   WIDTH   datapath width of operands, result and the shared adder
//
// Ports
//   clk     in   1      rising-edge clock
//   clr     in   1      asynchronous active-high reset
//   start   in   1      request, sampled only in IDLE and DONE
//   op      in   2      00 ADD, 01 SUB, 10 NEG, 11 PASS
//   a       in   WIDTH  operand A, captured on an accepted start
//   b       in   WIDTH  operand B, captured on an accepted start
//   busy    out  1      high while in PASS1/PASS2
//   done    out  1      one-cycle pulse when result/flags are newly updated
//   result  out  WIDTH  final sum, held until the next done
//   c_out   out  1      carry out of the final adder pass
//   ovf     out  1      signed overflow of the requested operation

module addsub_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NEG  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] tmp_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             commit;

    // Operand steering for the single shared adder. Negation is done as
    // inverter + constant 1 on the second adder input, so the adder's own
    // carry-in is never needed. Outside the pass states the adder idles on
    // (a_q, 0), which nothing consumes.
    always_comb begin
        add_a = a_q;
        add_b = '0;
        case (state_q)
            PASS1: begin
                case (op_q)
                    OP_ADD: begin
                        add_a = a_q;
                        add_b = b_q;
                    end
                    OP_SUB: begin
                        add_a = ~b_q;
                        add_b = ONE;
                    end
                    OP_NEG: begin
                        add_a = ~a_q;
                        add_b = ONE;
                    end
                    OP_PASS: begin
                        add_a = a_q;
                        add_b = '0;
                    end
                    default: begin
                        add_a = a_q;
                        add_b = '0;
                    end
                endcase
            end
            PASS2: begin
                add_a = a_q;
                add_b = tmp_q;
            end
            default: begin
                add_a = a_q;
                add_b = '0;
            end
        endcase
    end

    // The final pass of every operation: PASS1 for single-pass ops, PASS2
    // for SUB. This is the only cycle in which the visible outputs update.
    assign commit = ((state_q == PASS1) && (op_q != OP_SUB)) || (state_q == PASS2);

`ifdef ADDSUB_SEQ_FLAGS_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] add_full;
    logic           add_carry;
    logic           ovf_d;
    logic           cout_q;
    logic           ovf_q;

    assign add_full  = {1'b0, add_a} + {1'b0, add_b};
    assign add_sum   = add_full[WIDTH-1:0];
    assign add_carry = add_full[WIDTH];

    // Overflow is judged from the original operands rather than the
    // negated b, so SUB with b = most-negative is still reported correctly.
    always_comb begin
        ovf_d = 1'b0;
        case (op_q)
            OP_ADD:  ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (add_sum[WIDTH-1] != a_q[WIDTH-1]);
            OP_SUB:  ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                             (add_sum[WIDTH-1] != a_q[WIDTH-1]);
            OP_NEG:  ovf_d = (a_q == MOST_NEG);
            OP_PASS: ovf_d = 1'b0;
            default: ovf_d = 1'b0;
        endcase
    end

    // Flag registers load together with the result on the committing pass.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (commit) begin
            cout_q <= add_carry;
            ovf_q  <= ovf_d;
        end
    end

    assign c_out = cout_q;
    assign ovf   = ovf_q;
`else
    assign add_sum = add_a + add_b;
    assign c_out   = 1'b0;
    assign ovf     = 1'b0;
`endif

    // Control FSM with registered busy/done. Operands are latched only when
    // a start is accepted in IDLE or DONE, so later input changes and starts
    // that arrive while busy have no effect on the running operation.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            tmp_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (commit) begin
                result_q <= add_sum;
            end
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        busy_q  <= 1'b1;
                        state_q <= PASS1;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                PASS1: begin
                    if (op_q == OP_SUB) begin
                        tmp_q   <= add_sum;
                        state_q <= PASS2;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                PASS2: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
// tb_addsub_sequencer
// -------------------
// Self-checking bench for addsub_sequencer: a directed vector table, a few
// hand-written handshake/reset sequences, and randomized operations checked
// against an arithmetic reference model. Flag expectations follow whether
// ADDSUB_SEQ_FLAGS_EN is defined for the build.

module tb_addsub_sequencer;

    localparam int W = 32;

`ifdef ADDSUB_SEQ_FLAGS_EN
    localparam bit flagsEn = 1'b1;
`else
    localparam bit flagsEn = 1'b0;
`endif

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NEG  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         ovf;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] prevResult;
    vec_t         vecs[$];

    addsub_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_out  (c_out),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Reference model from plain arithmetic: result mod 2^W, carry of the
    // final adder pass, overflow as the true signed result leaving range.
    function automatic void refModel(input logic [1:0] o, input logic [W-1:0] x,
                                     input logic [W-1:0] y, output logic [W-1:0] r,
                                     output logic c, output logic v);
        longint unsigned modulus = 64'h1_0000_0000;
        longint unsigned ux = {32'd0, x};
        longint unsigned uy = {32'd0, y};
        longint unsigned full;
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint          s;
        r = x;
        c = 1'b0;
        v = 1'b0;
        s = 0;
        case (o)
            OP_ADD: begin
                full = ux + uy;
                r = W'(full);
                c = (full >= modulus);
                s = sx + sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                full = ux + ((modulus - uy) % modulus);
                r = W'(full);
                c = (full >= modulus);
                s = sx - sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_NEG: begin
                r = W'((modulus - ux) % modulus);
                c = (ux == 0);
                s = -sx;
                v = (s > 64'sd2147483647);
            end
            default: begin
                r = x;
                c = 1'b0;
                v = 1'b0;
            end
        endcase
    endfunction

    // Issue one operation and wait for done. Inputs are scrambled after
    // acceptance to show that only the latched copies matter.
    task automatic applyStimulus(input logic [1:0] opIn, input logic [W-1:0] aIn,
                                 input logic [W-1:0] bIn, output int latency);
        @(negedge clk);
        start = 1'b1;
        op    = opIn;
        a     = aIn;
        b     = bIn;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        op      = 2'($urandom);
        a       = $urandom;
        b       = $urandom;
        latency = 1;
        checkOutput("busyPass1", W'(busy), W'(1));
        checkOutput("resultHeld", result, prevResult);
        while (!done && latency < 8) begin
            @(negedge clk);
            latency++;
        end
    endtask

    task automatic runOp(input string name, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] er, input logic ec,
                         input logic ev, input int elat);
        int lat;
        applyStimulus(o, x, y, lat);
        checkOutput({name, " latency"}, W'(lat), W'(elat));
        checkOutput({name, " result"}, result, er);
        checkOutput({name, " c_out"}, W'(c_out), W'(ec & flagsEn));
        checkOutput({name, " ovf"}, W'(ovf), W'(ev & flagsEn));
        checkOutput({name, " busyDone"}, W'(busy), W'(0));
        @(negedge clk);
        checkOutput({name, " donePulse"}, W'(done), W'(0));
        checkOutput({name, " resultHold"}, result, er);
        prevResult = er;
    endtask

    task automatic addVec(input string n, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] r, input logic c,
                          input logic v);
        vec_t t;
        t.name = n;
        t.op   = o;
        t.a    = x;
        t.b    = y;
        t.r    = r;
        t.c    = c;
        t.v    = v;
        t.lat  = (o == OP_SUB) ? 3 : 2;
        vecs.push_back(t);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] mr;
        logic         mc;
        logic         mv;
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        addVec("add5p7",    OP_ADD,  32'd5,          32'd7,          32'd12,         1'b0, 1'b0);
        addVec("sub3m5",    OP_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b0);
        addVec("sub5m3",    OP_SUB,  32'd5,          32'd3,          32'd2,          1'b1, 1'b0);
        addVec("negMin",    OP_NEG,  32'h8000_0000,  32'd0,          32'h8000_0000,  1'b0, 1'b1);
        addVec("neg1",      OP_NEG,  32'd1,          32'd9,          32'hFFFF_FFFF,  1'b0, 1'b0);
        addVec("addOvf",    OP_ADD,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1);
        addVec("addWrap",   OP_ADD,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0);
        addVec("pass",      OP_PASS, 32'hDEAD_BEEF,  32'h1234,       32'hDEAD_BEEF,  1'b0, 1'b0);
        addVec("subMinB",   OP_SUB,  32'd0,          32'h8000_0000,  32'h8000_0000,  1'b0, 1'b1);
        addVec("neg0",      OP_NEG,  32'd0,          32'd5,          32'd0,          1'b1, 1'b0);
        addVec("subB0",     OP_SUB,  32'd7,          32'd0,          32'd7,          1'b0, 1'b0);
        addVec("subMinM1",  OP_SUB,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b1, 1'b1);

        clr   = 1'b1;
        start = 1'b0;
        op    = OP_ADD;
        a     = '0;
        b     = '0;
        prevResult = '0;
        #12;
        checkOutput("rst busy", W'(busy), W'(0));
        checkOutput("rst done", W'(done), W'(0));
        checkOutput("rst result", result, '0);
        checkOutput("rst c_out", W'(c_out), W'(0));
        checkOutput("rst ovf", W'(ovf), W'(0));
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].lat);
        end

        // A start arriving during PASS1 must be dropped.
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 32'd5; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        op = OP_SUB; a = 32'd100; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("ignore done", W'(done), W'(1));
        checkOutput("ignore result", result, 32'd12);
        @(negedge clk);
        checkOutput("ignore idleDone", W'(done), W'(0));
        checkOutput("ignore idleBusy", W'(busy), W'(0));
        prevResult = 32'd12;

        // Back-to-back: start in the DONE cycle is accepted immediately.
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("b2b firstDone", W'(done), W'(1));
        checkOutput("b2b firstResult", result, 32'd3);
        start = 1'b1; op = OP_SUB; a = 32'd10; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        checkOutput("b2b busy", W'(busy), W'(1));
        while (!done && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("b2b latency", W'(lat), W'(3));
        checkOutput("b2b result", result, 32'd7);
        checkOutput("b2b c_out", W'(c_out), W'(flagsEn));
        @(negedge clk);
        checkOutput("b2b donePulse", W'(done), W'(0));
        prevResult = 32'd7;

        // Reset during SUB PASS2 discards the operation at once.
        @(negedge clk);
        start = 1'b1; op = OP_SUB; a = 32'd9; b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        clr = 1'b1;
        #1;
        checkOutput("clr result", result, '0);
        checkOutput("clr busy", W'(busy), W'(0));
        checkOutput("clr done", W'(done), W'(0));
        @(negedge clk);
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("clr noDone", W'(done), W'(0));
        end
        prevResult = '0;
        runOp("postClrAdd", OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 2);

        // Randomized operations, biased toward sign-boundary operands.
        for (int n = 0; n < 150; n++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
            if ($urandom_range(0, 3) == 0) rb = {rb[W-1], {(W-1){~rb[W-1]}}};
            refModel(ro, ra, rb, mr, mc, mv);
            runOp("rand", ro, ra, rb, mr, mc, mv, (ro == OP_SUB) ? 3 : 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
